// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit: aligns requests, runs the req/ack bus handshake, extends load data
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mem_op,
    input  logic [2:0]  mem_read_type,
    input  logic [3:0]  mem_write_mask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault_misalign,
    output logic        fault_timeout,
    output logic        fault_invalid,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [2:0] RD_BYTE  = 3'b000;
    localparam logic [2:0] RD_HALF  = 3'b001;
    localparam logic [2:0] RD_WORD  = 3'b010;
    localparam logic [2:0] RD_BU    = 3'b100;
    localparam logic [2:0] RD_HU    = 3'b101;
    localparam logic [3:0] WR_BYTE  = 4'b0001;
    localparam logic [3:0] WR_HALF  = 4'b0011;
    localparam logic [3:0] WR_WORD  = 4'b1111;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  rtype_q, rtype_d;
    logic [31:0] rdata_q, rdata_d;
    logic        f_inv_q, f_inv_d;
    logic        f_mis_q, f_mis_d;
    logic        f_to_q, f_to_d;

    logic        is_load, is_store, req_half, req_word, req_invalid, req_misalign;
    logic [31:0] lane, load_val;

    always_comb begin
        is_load      = (mem_op == OP_LOAD);
        is_store     = (mem_op == OP_STORE);
        req_half     = (is_load && (mem_read_type == RD_HALF || mem_read_type == RD_HU)) ||
                       (is_store && mem_write_mask == WR_HALF);
        req_word     = (is_load && mem_read_type == RD_WORD) || (is_store && mem_write_mask == WR_WORD);
        req_invalid  = (mem_op == 2'b11) ||
                       (is_load && !(mem_read_type inside {RD_BYTE, RD_HALF, RD_WORD, RD_BU, RD_HU})) ||
                       (is_store && !(mem_write_mask inside {WR_BYTE, WR_HALF, WR_WORD}));
        req_misalign = (req_half && addr[0]) || (req_word && addr[1:0] != 2'b00);
    end

    always_comb begin
        lane = bus_rdata >> {off_q, 3'b000};
        case (rtype_q)
            RD_BYTE: load_val = {{24{lane[7]}}, lane[7:0]};
            RD_HALF: load_val = {{16{lane[15]}}, lane[15:0]};
            RD_BU:   load_val = {24'd0, lane[7:0]};
            RD_HU:   load_val = {16'd0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        off_d   = off_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rtype_d = rtype_q;
        rdata_d = rdata_q;
        f_inv_d = f_inv_q;
        f_mis_d = f_mis_q;
        f_to_d  = f_to_q;
        case (state_q)
            S_IDLE: if (start) begin
                addr_d  = {addr[31:2], 2'b00};
                off_d   = addr[1:0];
                we_d    = is_store;
                wstrb_d = is_store ? (mem_write_mask << addr[1:0]) : 4'b0000;
                wdata_d = wdata << {addr[1:0], 3'b000};
                rtype_d = mem_read_type;
                cnt_d   = 8'd0;
                f_inv_d = req_invalid;
                f_mis_d = !req_invalid && req_misalign;
                f_to_d  = 1'b0;
                state_d = (mem_op == OP_NONE || req_invalid || req_misalign) ? S_DONE : S_BUS;
            end
            S_BUS: begin
                // An ack on the last permitted cycle still wins over the timeout.
                if (bus_ack) begin
                    if (!we_q) rdata_d = load_val;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    f_to_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rtype_q <= '0;
            rdata_q <= '0;
            f_inv_q <= 1'b0;
            f_mis_q <= 1'b0;
            f_to_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rtype_q <= rtype_d;
            rdata_q <= rdata_d;
            f_inv_q <= f_inv_d;
            f_mis_q <= f_mis_d;
            f_to_q  <= f_to_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign bus_req        = (state_q == S_BUS);
    assign rdata          = rdata_q;
    assign fault_invalid  = done && f_inv_q;
    assign fault_misalign = done && f_mis_q;
    assign fault_timeout  = done && f_to_q;
    assign bus_we         = we_q;
    assign bus_addr       = addr_q;
    assign bus_wstrb      = wstrb_q;
    assign bus_wdata      = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [2:0] RD_BYTE  = 3'b000;
    localparam logic [2:0] RD_HALF  = 3'b001;
    localparam logic [2:0] RD_WORD  = 3'b010;
    localparam logic [2:0] RD_BU    = 3'b100;
    localparam logic [2:0] RD_HU    = 3'b101;
    localparam logic [2:0] RD_NONE  = 3'b111;
    localparam logic [3:0] WR_BYTE  = 4'b0001;
    localparam logic [3:0] WR_HALF  = 4'b0011;
    localparam logic [3:0] WR_WORD  = 4'b1111;
    localparam logic [3:0] WR_NONE  = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mem_op = '0;
    logic [2:0]  mem_read_type = '0;
    logic [3:0]  mem_write_mask = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, fault_misalign, fault_timeout, fault_invalid, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int failures = 0;
    logic [34:0] sb[$];
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_op(mem_op), .mem_read_type(mem_read_type),
        .mem_write_mask(mem_write_mask), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .fault_misalign(fault_misalign), .fault_timeout(fault_timeout),
        .fault_invalid(fault_invalid), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    // Drives one request starting just after an edge and plays the bus slave until done.
    task automatic run_access(input logic [1:0] op, input logic [2:0] rt, input logic [3:0] mask,
                              input logic [31:0] a, input logic [31:0] wd, input int ack_after,
                              input logic [31:0] rword, input bit poke,
                              output int lat, output int reqc, output logic [34:0] got,
                              output logic [31:0] baddr, output logic [3:0] bstrb,
                              output logic [31:0] bwdata, output logic bwe, output bit stable);
        lat = -1; reqc = 0; got = '0; baddr = '0; bstrb = '0; bwdata = '0; bwe = 1'b0; stable = 1'b1;
        mem_op = op; mem_read_type = rt; mem_write_mask = mask; addr = a; wdata = wd; start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = c;
                got = {rdata, fault_invalid, fault_misalign, fault_timeout};
                break;
            end
            if (bus_req) begin
                reqc++;
                if (reqc == 1) begin
                    baddr = bus_addr; bstrb = bus_wstrb; bwdata = bus_wdata; bwe = bus_we;
                end else if (bus_addr !== baddr || bus_wstrb !== bstrb || bus_wdata !== bwdata || bus_we !== bwe) begin
                    stable = 1'b0;
                end
                bus_ack = (reqc == ack_after);
                bus_rdata = bus_ack ? rword : 32'hDEAD_BEEF;
                if (poke && reqc == 1) begin
                    start = 1'b1; mem_op = OP_STORE; mem_write_mask = WR_WORD; addr = 32'h999; wdata = 32'h5555_5555;
                end
            end else begin
                bus_ack = 1'b0;
            end
        end
        bus_ack = 1'b0; start = 1'b0; mem_op = OP_NONE;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, rdata, fault_misalign, fault_timeout, fault_invalid, bus_req, bus_we,
             bus_addr, bus_wstrb, bus_wdata} !== '0) begin
            failures++; $display("FAIL reset_outputs: got busy=%b done=%b bus_req=%b rdata=%h expected all zero",
                                 busy, done, bus_req, rdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_extract();
        logic [2:0]  rts [5] = '{RD_BYTE, RD_HALF, RD_WORD, RD_BU, RD_HU};
        logic [31:0] as  [5] = '{32'h103, 32'h000, 32'h004, 32'h101, 32'h302};
        logic [31:0] ws  [5] = '{32'h80FF_FF12, 32'h1234_F00D, 32'h1234_F00D, 32'h0000_AB00, 32'h8001_0000};
        logic [31:0] exs [5] = '{32'hFFFF_FF80, 32'hFFFF_F00D, 32'h1234_F00D, 32'h0000_00AB, 32'h0000_8001};
        int lat, reqc; logic [34:0] got, exp; logic [31:0] ba, bwd; logic [3:0] bs; logic bw; bit st;
        for (int i = 0; i < 5; i++) begin
            sb.push_back({exs[i], 3'b000});
            run_access(OP_LOAD, rts[i], WR_NONE, as[i], 32'h0, 1, ws[i], 1'b0, lat, reqc, got, ba, bs, bwd, bw, st);
            exp = sb.pop_front();
            last_rd = exs[i];
            checks++;
            if (got !== exp) begin failures++; $display("FAIL load_%0d_result: got %h expected %h", i, got, exp); end
            checks++;
            if (lat != 2 || reqc != 1) begin failures++; $display("FAIL load_%0d_latency: got lat=%0d req=%0d expected 2/1", i, lat, reqc); end
            checks++;
            if ({ba, bs, bw} !== {as[i][31:2], 2'b00, 4'b0000, 1'b0}) begin
                failures++; $display("FAIL load_%0d_bus: got addr=%h strb=%b we=%b expected addr=%h strb=0000 we=0",
                                     i, ba, bs, bw, {as[i][31:2], 2'b00});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        logic [3:0]  ms  [3] = '{WR_HALF, WR_BYTE, WR_WORD};
        logic [31:0] as  [3] = '{32'h202, 32'h003, 32'h008};
        logic [31:0] wds [3] = '{32'h0000_BEEF, 32'h0000_00AB, 32'h1122_3344};
        logic [3:0]  ess [3] = '{4'b1100, 4'b1000, 4'b1111};
        logic [31:0] ews [3] = '{32'hBEEF_0000, 32'hAB00_0000, 32'h1122_3344};
        int lat, reqc; logic [34:0] got, exp; logic [31:0] ba, bwd; logic [3:0] bs; logic bw; bit st;
        for (int i = 0; i < 3; i++) begin
            sb.push_back({last_rd, 3'b000});
            run_access(OP_STORE, RD_NONE, ms[i], as[i], wds[i], 3, 32'hFFFF_FFFF, 1'b0, lat, reqc, got, ba, bs, bwd, bw, st);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin failures++; $display("FAIL store_%0d_result: got %h expected %h", i, got, exp); end
            checks++;
            if (lat != 4 || reqc != 3 || !st) begin failures++; $display("FAIL store_%0d_timing: got lat=%0d req=%0d stable=%0d expected 4/3/1", i, lat, reqc, st); end
            checks++;
            if ({ba, bs, bwd, bw} !== {as[i][31:2], 2'b00, ess[i], ews[i], 1'b1}) begin
                failures++; $display("FAIL store_%0d_bus: got addr=%h strb=%b wdata=%h we=%b expected strb=%b wdata=%h we=1",
                                     i, ba, bs, bwd, bw, ess[i], ews[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_faults();
        logic [1:0]  ops [6] = '{OP_LOAD, OP_STORE, OP_LOAD, OP_LOAD, OP_STORE, OP_NONE};
        logic [2:0]  rts [6] = '{RD_WORD, RD_NONE, RD_HU, RD_NONE, RD_NONE, RD_NONE};
        logic [3:0]  ms  [6] = '{WR_NONE, WR_HALF, WR_NONE, WR_NONE, WR_NONE, WR_NONE};
        logic [31:0] as  [6] = '{32'h201, 32'h203, 32'h001, 32'h201, 32'h200, 32'h201};
        logic [2:0]  efs [6] = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b000};
        int lat, reqc; logic [34:0] got, exp; logic [31:0] ba, bwd; logic [3:0] bs; logic bw; bit st;
        for (int i = 0; i < 6; i++) begin
            sb.push_back({last_rd, efs[i]});
            run_access(ops[i], rts[i], ms[i], as[i], 32'h0, 1, 32'h0, 1'b0, lat, reqc, got, ba, bs, bwd, bw, st);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin failures++; $display("FAIL fault_%0d_result: got %h expected %h", i, got, exp); end
            checks++;
            if (lat != 1 || reqc != 0) begin failures++; $display("FAIL fault_%0d_nobus: got lat=%0d req=%0d expected 1/0", i, lat, reqc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        int lat, reqc; logic [34:0] got, exp; logic [31:0] ba, bwd; logic [3:0] bs; logic bw; bit st;
        sb.push_back({last_rd, 3'b001});
        run_access(OP_LOAD, RD_WORD, WR_NONE, 32'h400, 32'h0, 0, 32'h0, 1'b0, lat, reqc, got, ba, bs, bwd, bw, st);
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL timeout_result: got %h expected %h", got, exp); end
        checks++;
        if (lat != 5 || reqc != 4 || bus_req !== 1'b0) begin
            failures++; $display("FAIL timeout_timing: got lat=%0d req=%0d bus_req=%b expected 5/4/0", lat, reqc, bus_req);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int lat, reqc; logic [34:0] got, exp; logic [31:0] ba, bwd; logic [3:0] bs; logic bw; bit st;
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_ack_ignored: got done=%b busy=%b expected 0/0", done, busy); end
        sb.push_back({32'h0000_7F00, 3'b000});
        run_access(OP_LOAD, RD_HALF, WR_NONE, 32'h102, 32'h0, 3, 32'h7F00_1234, 1'b1, lat, reqc, got, ba, bs, bwd, bw, st);
        exp = sb.pop_front();
        last_rd = 32'h0000_7F00;
        checks++;
        if (got !== exp) begin failures++; $display("FAIL busy_start_result: got %h expected %h", got, exp); end
        checks++;
        if (lat != 4 || !st || ba !== 32'h100 || bw !== 1'b0) begin
            failures++; $display("FAIL busy_start_ignored: got lat=%0d stable=%0d addr=%h we=%b expected 4/1/00000100/0", lat, st, ba, bw);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL busy_start_not_queued: got done=%b busy=%b expected 0/0", done, busy); end
    endtask

    task automatic test_back_to_back();
        int lat, reqc; logic [34:0] got, exp; logic [31:0] ba, bwd; logic [3:0] bs; logic bw; bit st;
        sb.push_back({32'h0000_0042, 3'b000});
        sb.push_back({32'hFFFF_FFC3, 3'b000});
        run_access(OP_LOAD, RD_BU, WR_NONE, 32'h010, 32'h0, 1, 32'h0000_0042, 1'b0, lat, reqc, got, ba, bs, bwd, bw, st);
        exp = sb.pop_front();
        checks++;
        if (got !== exp || lat != 2) begin failures++; $display("FAIL b2b_first: got %h lat=%0d expected %h lat=2", got, lat, exp); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL done_single_pulse: got done=%b expected 0", done); end
        run_access(OP_LOAD, RD_BYTE, WR_NONE, 32'h012, 32'h0, 1, 32'h00C3_0000, 1'b0, lat, reqc, got, ba, bs, bwd, bw, st);
        exp = sb.pop_front();
        last_rd = 32'hFFFF_FFC3;
        checks++;
        if (got !== exp || lat != 2) begin failures++; $display("FAIL b2b_second: got %h lat=%0d expected %h lat=2", got, lat, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_bus();
        int seen = 0;
        mem_op = OP_LOAD; mem_read_type = RD_WORD; addr = 32'h500; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (bus_req !== 1'b1) begin failures++; $display("FAIL mid_bus_entered: got bus_req=%b expected 1", bus_req); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, rdata, fault_misalign, fault_timeout, fault_invalid, bus_req, bus_we,
             bus_addr, bus_wstrb, bus_wdata} !== '0) begin
            failures++; $display("FAIL mid_bus_reset: got busy=%b bus_req=%b rdata=%h bus_addr=%h expected all zero",
                                 busy, bus_req, rdata, bus_addr);
        end
        rst_n = 1'b1; mem_op = OP_NONE;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL mid_bus_no_done: got %0d active cycles expected 0", seen); end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drained: got %0d left expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_load_extract();
        test_store();
        test_faults();
        test_timeout();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
